// File: rtl/simple_pipe_fetch.sv
// ---------------------------------------------------------------------------
// simple_pipe_fetch
//
// Instruction fetch front-end for the 4-register simple pipeline. Holds the
// PC, issues in-order requests to an instruction memory, and buffers returned
// instructions in a small prefetch FIFO. A NOP (8'h00) bubble is presented
// whenever no buffered instruction can be issued.
//
// Request credits: a request may only be issued when the FIFO occupancy plus
// the number of in-flight requests is below DEPTH, so every response that
// comes back is guaranteed a FIFO slot. No response backpressure is needed.
//
// Redirect: the PC is reloaded, the FIFO is flushed, and every request still
// in flight is marked stale so that its response is discarded on arrival.
//
// Ports:
//   clk              clock, all state updates on posedge
//   rst              synchronous active-high reset
//   imem_req_valid   fetch request valid
//   imem_req_ready   memory accepts request
//   imem_req_addr    fetch address (current PC)
//   imem_resp_valid  response valid (in request order, no backpressure)
//   imem_resp_data   returned instruction
//   halt             hold issue: emit NOP, do not pop
//   redirect_valid   reload PC from redirect_pc this cycle
//   redirect_pc      new PC
//   inst             instruction to the ID stage (8'h00 when not valid)
//   inst_valid       inst carries a fetched instruction
//   pc_out           current PC (next address to request)
//   proto_err        sticky: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module simple_pipe_fetch #(
  parameter int                 ADDR_W   = 8,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [7:0]        imem_resp_data,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [7:0]        inst,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  // Counters must be able to hold the value DEPTH itself.
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [PTR_W-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [CNT_W-1:0]  count_q,     count_d;
  logic [CNT_W-1:0]  outst_q,     outst_d;
  logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;
  logic              proto_err_q, proto_err_d;

  logic [7:0]        fifo_mem_q [DEPTH];

  // -------------------------------------------------------------------------
  // Event decode
  // -------------------------------------------------------------------------
  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           resp_ok;     // response matched to an outstanding request
  logic           resp_orphan; // response with nothing outstanding
  logic           push;
  logic           pop;
  logic           fifo_nonempty;

  assign credit_used   = {1'b0, count_q} + {1'b0, outst_q};
  assign fifo_nonempty = (count_q != '0);

  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DEPTH_V);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_ok     = imem_resp_valid && (outst_q != '0);
  assign resp_orphan = imem_resp_valid && (outst_q == '0);

  // Stale responses are swallowed; a response arriving in a redirect cycle is
  // also stale because the FIFO is being flushed underneath it.
  assign push = resp_ok && (drop_cnt_q == '0) && !redirect_valid;

  // Redirect outranks halt; both suppress issue. Holding inst_valid low during
  // rst keeps the output quiet before the first reset edge has landed.
  assign inst_valid = !rst && fifo_nonempty && !halt && !redirect_valid;
  assign pop        = inst_valid;
  assign inst       = inst_valid ? fifo_mem_q[rd_ptr_q] : 8'h00;

  assign pc_out    = pc_q;
  assign proto_err = proto_err_q;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d        = pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    outst_d     = outst_q;
    drop_cnt_d  = drop_cnt_q;
    proto_err_d = proto_err_q || resp_orphan;

    // Outstanding tracks every in-flight request, stale ones included, so the
    // credit check stays exact across redirects.
    case ({req_fire, resp_ok})
      2'b10:   outst_d = outst_q + ONE_C;
      2'b01:   outst_d = outst_q - ONE_C;
      default: outst_d = outst_q;
    endcase

    if (redirect_valid) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      // Everything still pending after this cycle's response is stale.
      drop_cnt_d = resp_ok ? (outst_q - ONE_C) : outst_q;
    end else begin
      if (req_fire) begin
        pc_d = pc_q + ADDR_W'(1);
      end
      if (resp_ok && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - ONE_C;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      outst_q     <= '0;
      drop_cnt_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  // FIFO storage needs no reset: count_q gates every read of it.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk) begin
        if (!rst && push && (wr_ptr_q == PTR_W'(gi))) begin
          fifo_mem_q[gi] <= imem_resp_data;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_simple_pipe_fetch.sv
// ---------------------------------------------------------------------------
// tb_simple_pipe_fetch
//
// Directed bench for simple_pipe_fetch. A small instruction-memory model
// answers accepted requests in order after a configurable latency with
// mem[a] = a + 8'h40. Expected instruction streams and addresses are
// hand-derived per scenario.
// ---------------------------------------------------------------------------
module tb_simple_pipe_fetch;

  logic       clk;
  logic       rst;
  logic       imem_req_valid;
  logic       imem_req_ready;
  logic [7:0] imem_req_addr;
  logic       imem_resp_valid;
  logic [7:0] imem_resp_data;
  logic       halt;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic [7:0] inst;
  logic       inst_valid;
  logic [7:0] pc_out;
  logic       proto_err;

  simple_pipe_fetch #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .halt            (halt),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .pc_out          (pc_out),
    .proto_err       (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] addr;
    int         due;
  } pend_t;

  pend_t      pend[$];
  int         cyc;
  int         lat;
  int         n_chk;
  int         n_pass;
  int         n_valid;
  logic [7:0] exp_next;

  // Sampled outputs of the most recent cycle
  logic       o_reqv, o_fire, o_iv, o_pe;
  logic [7:0] o_addr, o_inst, o_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
      $display("ok   %-12s got %0h", tag, obs);
    end else begin
      $display("FAIL %-12s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] memf(input logic [7:0] a);
    return a + 8'h40;
  endfunction

  // One clock cycle: sample settled outputs, check the instruction stream,
  // record accepted requests, then advance the memory model past the edge.
  task automatic cycle();
    #2;
    o_reqv = imem_req_valid;
    o_fire = imem_req_valid && imem_req_ready;
    o_addr = imem_req_addr;
    o_iv   = inst_valid;
    o_inst = inst;
    o_pc   = pc_out;
    o_pe   = proto_err;
    if (o_fire) pend.push_back('{addr: o_addr, due: cyc + lat});
    if (o_iv) begin
      chk("inst", {24'd0, o_inst}, {24'd0, exp_next});
      exp_next = exp_next + 8'h01;
      n_valid++;
    end else begin
      chk("nop", {24'd0, o_inst}, 32'h0);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = memf(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 8'h00;
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    halt            = 1'b0;
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 8'h00;
    pend.delete();
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    cyc      = 0;
    n_valid  = 0;
    exp_next = 8'h40;
  endtask

  initial begin
    logic [7:0] wrap_tab [4];
    int nf;
    int guard;
    bit first_fire;

    n_chk = 0; n_pass = 0; n_valid = 0; cyc = 0; lat = 1;
    exp_next = 8'h40;
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
    imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = 8'h00;

    // ---- reset state -----------------------------------------------------
    @(posedge clk);
    #2;
    chk("rst_reqv",  {31'd0, imem_req_valid}, 32'd0);
    chk("rst_iv",    {31'd0, inst_valid},     32'd0);
    chk("rst_inst",  {24'd0, inst},           32'h0);
    chk("rst_pc",    {24'd0, pc_out},         32'h0);
    chk("rst_perr",  {31'd0, proto_err},      32'd0);

    // ---- steady stream, 1-cycle memory -----------------------------------
    lat = 1;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      cycle();
      chk("s_fire", {31'd0, o_fire}, 32'd1);
      chk("s_addr", {24'd0, o_addr}, 32'(c));
      chk("s_iv",   {31'd0, o_iv},   32'(c >= 2));
    end

    // ---- halt: FIFO fills, requests stop, nothing lost on release --------
    halt = 1'b1;
    nf = 0;
    for (int h = 0; h < 10; h++) begin
      cycle();
      chk("h_iv", {31'd0, o_iv}, 32'd0);
      if (o_fire) nf++;
      if (h == 9) chk("h_reqv_end", {31'd0, o_reqv}, 32'd0);
    end
    chk("h_fires", 32'(nf), 32'd2);
    halt = 1'b0;
    for (int r = 0; r < 4; r++) begin
      cycle();
      chk("rel_iv", {31'd0, o_iv}, 32'd1);
    end

    // ---- ready toggling: bubble every other cycle ------------------------
    do_reset();
    for (int c = 0; c < 10; c++) begin
      imem_req_ready = (c % 2 == 0);
      cycle();
      chk("t_pc", {24'd0, o_pc}, 32'((c + 1) / 2));
      chk("t_iv", {31'd0, o_iv}, 32'((c >= 2) && (c % 2 == 0)));
    end
    imem_req_ready = 1'b1;

    // ---- redirect with 3 outstanding, 3-cycle memory ---------------------
    lat = 3;
    do_reset();
    guard = 0;
    while (!((pend.size() + int'(imem_resp_valid)) == 3 && exp_next == 8'h44) && guard < 30) begin
      cycle();
      guard++;
    end
    chk("r_setup", 32'(guard < 30), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    exp_next       = 8'hC0;
    cycle();
    chk("r_cyc_iv",   {31'd0, o_iv},   32'd0);
    chk("r_cyc_reqv", {31'd0, o_reqv}, 32'd0);
    redirect_valid = 1'b0;
    n_valid    = 0;
    first_fire = 1'b0;
    for (int k = 0; k < 12; k++) begin
      cycle();
      if (k == 0) chk("r_pc", {24'd0, o_pc}, 32'h80);
      if (o_fire && !first_fire) begin
        first_fire = 1'b1;
        chk("r_addr", {24'd0, o_addr}, 32'h80);
      end
    end
    chk("r_got_new", 32'(n_valid >= 3), 32'd1);

    // ---- PC wrap: FE, FF, 00, 01 -----------------------------------------
    lat = 1;
    do_reset();
    wrap_tab[0] = 8'hFE; wrap_tab[1] = 8'hFF; wrap_tab[2] = 8'h00; wrap_tab[3] = 8'h01;
    redirect_valid = 1'b1;
    redirect_pc    = 8'hFE;
    exp_next       = 8'h3E;
    cycle();
    redirect_valid = 1'b0;
    n_valid = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("w_fire", {31'd0, o_fire}, 32'd1);
      chk("w_addr", {24'd0, o_addr}, {24'd0, wrap_tab[i]});
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (i == 0) chk("w_pc", {24'd0, o_pc}, 32'h02);
    end
    chk("w_ninst", 32'(n_valid), 32'd4);
    imem_req_ready = 1'b1;

    // ---- orphan response sets sticky proto_err ---------------------------
    do_reset();
    imem_req_ready = 1'b0;
    cycle();
    cycle();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 8'h99;
    cycle();
    chk("p_before", {31'd0, o_pe}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("p_sticky", {31'd0, o_pe}, 32'd1);
      chk("p_iv",     {31'd0, o_iv}, 32'd0);
    end
    do_reset();
    cycle();
    chk("p_cleared", {31'd0, o_pe}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
